memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Multi-core RAM arbiter for the coherent MIPS system. It sits between the per-core instruction/data cache request ports and the single shared RAM port. It grants the RAM to one requester at a time using a round-robin pointer, and holds that grant until RAM reports `ACCESS`. It then releases the owner's wait for exactly one cycle and rotates priority, so no core or port starves.

## Interface
- `CPUS`, 2, number of cores; each core has one I port and one D port.
- `CLK`  in  1  system clock, rising-edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  CPUS  instruction read request, per core.
- `dREN`  in  CPUS  data read request, per core.
- `dWEN`  in  CPUS  data write request, per core.
- `iaddr`  in  32*CPUS  instruction word address, core c at bits [32c+31:32c].
- `daddr`  in  32*CPUS  data word address, same packing.
- `dstore`  in  32*CPUS  write data, same packing.
- `iwait`  out  CPUS  1 = I request not complete.
- `dwait`  out  CPUS  1 = D request not complete.
- `iload`  out  32*CPUS  read data to each I port.
- `dload`  out  32*CPUS  read data to each D port.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.

## Operation
- **Source numbering:** s = 2c is core c's D port; s = 2c+1 is core c's I port. A D source is active when `dREN|dWEN`; an I source is active when `iREN`.
- **Registers:**
  - `state` ∈ {IDLE, GRANT}
  - `owner` (source index)
  - `rp` (round-robin pointer, 0..2*CPUS-1)
- **IDLE:**
  - All RAM enables are 0.
  - Scan active sources starting at `rp`, wrapping modulo 2*CPUS. The first hit is latched into `owner` and the FSM goes to GRANT.
  - With no active source, stay in IDLE.
- **GRANT:**
  - `ramaddr` and `ramstore` are driven live from the owner's inputs.
  - A D owner drives `ramWEN=dWEN[c]`, `ramREN=dREN[c] & ~dWEN[c]`. Write wins if both are set.
  - An I owner drives `ramREN=iREN[c]`.
  - On `ramstate==ACCESS`:
    - Drive the owner's wait bit to 0 combinationally in that cycle.
    - Next state is IDLE, with `rp <= owner+1` modulo 2*CPUS.
  - If the owner drops its request while in GRANT:
    - Abort to IDLE on the next edge with no ack.
    - `rp` is unchanged.
  - On `ramstate==ERROR`: abort to IDLE, `rp` unchanged, and the request is re-arbitrated (retried).
  - On FREE or BUSY: remain in GRANT.
- **Wait bits:** every wait bit not being acked is 1, including wait bits for idle ports.
- **Load data:** `iload` and `dload` broadcast `ramload` to all ports. Only the acked port samples it.
- **Reset mid-transaction:**
  - The owner receives no ack.
  - RAM enables drop asynchronously.
  - After reset, arbitration restarts from `rp=0`.

## Timing
- **Reset values:**
  - state = IDLE, `rp` = 0, `owner` = 0.
  - `iwait` and `dwait` all 1.
  - `ramREN`, `ramWEN` = 0.
  - `ramaddr`, `ramstore` = 0.
- **Grant latency:** a request present at edge t puts the RAM enables high in cycle t+1.
- **Acknowledge:** the ack (wait=0) coincides exactly with the ACCESS cycle and lasts one cycle.
- **Transaction cost:** one IDLE cycle separates consecutive grants, so the minimum is 2 cycles per transaction with an ACCESS-on-first-cycle RAM.
- **Fairness bound:** a continuously asserted request is served within 2*CPUS grants without the macro, or CPUS grants for D ports with the macro. With the macro, I-port service is bounded only when the D ports go quiet.

## Configuration
- `ARB_DATA_PRIORITY_EN`:
  - **Defined:** the IDLE scan first considers only D sources from `rp`. If none are active, it then scans I sources from `rp`. Any data request beats any instruction request.
  - **Undefined:** a single flat round-robin scan over all 2*CPUS sources.

## Test plan
- **Reset:** hold `nRST=0` with requests active -> all waits 1, `ramREN`/`ramWEN` 0. Release -> first grant at the next edge plus one cycle.
- **Single instruction fetch:** `iREN[0]=1`, `iaddr=0x40`, RAM returns ACCESS after 3 BUSY cycles with `ramload=0xDEADBEEF` -> `ramaddr=0x40`, `iwait[0]=0` for exactly 1 cycle, `iload` core 0 = 0xDEADBEEF.
- **Write:** `dWEN[1]=1`, `daddr=0x80`, `dstore=0x1234` -> `ramWEN=1`, `ramREN=0`, `ramaddr=0x80`, `ramstore=0x1234`, `dwait[1]` low on the ACCESS cycle.
- **All four ports requesting constantly, RAM ACCESS every cycle:**
  - Without the macro, grant order is s=0,1,2,3,0…
  - With the macro, grant order is d0,d1,d0,d1 and `iwait` stays 1.
- **Owner drops request in GRANT:** `dREN[0]` deasserts mid-BUSY -> no `dwait[0]` ack, return to IDLE, `rp` unchanged, next requester granted.
- **ERROR and simultaneous read/write:**
  - `ramstate=ERROR` during GRANT -> no ack, the same request is re-granted 2 cycles later.
  - `dREN=dWEN=1` -> RAM sees a write only.

Source files
------------

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter of per-core I/D cache ports onto one shared RAM port
//
// Grants the RAM to one source at a time and holds the grant until RAM reports
// ACCESS. The owner's wait bit drops for that one cycle, and priority then
// rotates past the owner. Source s = 2c is core c's D port and s = 2c+1 is
// core c's I port.
//
// Optional feature macro: ARB_DATA_PRIORITY_EN
//   defined   - any active D source beats any active I source (round-robin within each class)
//   undefined - one flat round-robin scan over all 2*CPUS sources
//
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   iREN[CPUS]                instruction read request per core
//   dREN[CPUS], dWEN[CPUS]    data read / write request per core
//   iaddr, daddr, dstore      32 bits per core, core c at [32c+31:32c]
//   iwait, dwait              1 = request of that port not complete this cycle
//   iload, dload              ramload broadcast to every port
//   ramREN, ramWEN            RAM enables, only while a grant is held
//   ramaddr, ramstore         owner's address / write data, 0 while idle
//   ramload, ramstate         RAM read data and status (FREE, BUSY, ACCESS, ERROR)

module memory_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [CPUS-1:0]     iREN,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  logic [32*CPUS-1:0]  iaddr,
    input  logic [32*CPUS-1:0]  daddr,
    input  logic [32*CPUS-1:0]  dstore,
    output logic [CPUS-1:0]     iwait,
    output logic [CPUS-1:0]     dwait,
    output logic [32*CPUS-1:0]  iload,
    output logic [32*CPUS-1:0]  dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate
);

    localparam int NS = 2 * CPUS;
    localparam int SW = $clog2(NS);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    // Even source indices are D ports.
    localparam logic [NS-1:0] D_MASK = {CPUS{2'b01}};

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SW-1:0]   r_owner;
    logic [SW-1:0]   w_next_owner;
    logic [SW-1:0]   r_rp;
    logic [SW-1:0]   w_next_rp;
    logic [NS-1:0]   w_active;
    logic [SW:0]     w_scan;       // {found, source index}
    logic [CW-1:0]   w_core;
    logic            w_own_i;
    logic            w_own_active;
    logic [31:0]     w_iaddr  [CPUS];
    logic [31:0]     w_daddr  [CPUS];
    logic [31:0]     w_dstore [CPUS];

    genvar g;
    generate
        for (g = 0; g < CPUS; g++) begin : g_src
            assign w_iaddr[g]      = iaddr[32*g +: 32];
            assign w_daddr[g]      = daddr[32*g +: 32];
            assign w_dstore[g]     = dstore[32*g +: 32];
            assign w_active[2*g]   = dREN[g] | dWEN[g];
            assign w_active[2*g+1] = iREN[g];
        end
    endgenerate

    // First set bit of req at or after start, wrapping. Iterating from the
    // farthest offset down lets the nearest hit overwrite the others.
    function automatic logic [SW:0] rr_scan(input logic [NS-1:0] req,
                                            input logic [SW-1:0] start);
        logic [SW:0]   res;
        logic [SW-1:0] idx;
        res = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            idx = SW'((int'(start) + k) % NS);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef ARB_DATA_PRIORITY_EN
    logic [SW:0] w_scan_d;
    assign w_scan_d = rr_scan(w_active & D_MASK, r_rp);
    assign w_scan   = w_scan_d[SW] ? w_scan_d : rr_scan(w_active & ~D_MASK, r_rp);
`else
    assign w_scan   = rr_scan(w_active, r_rp);
`endif

    assign w_core       = CW'(r_owner >> 1);
    assign w_own_i      = r_owner[0];
    assign w_own_active = w_active[r_owner];

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rp    <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_rp    <= w_next_rp;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_rp    = r_rp;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = '1;
        dwait        = '1;
        case (r_state)
            IDLE: begin
                if (w_scan[SW]) begin
                    w_next_owner = w_scan[SW-1:0];
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                if (w_own_i) begin
                    ramaddr = w_iaddr[w_core];
                    ramREN  = iREN[w_core];
                end else begin
                    ramaddr  = w_daddr[w_core];
                    ramstore = w_dstore[w_core];
                    // Write wins when a D port raises both enables.
                    ramWEN   = dWEN[w_core];
                    ramREN   = dREN[w_core] & ~dWEN[w_core];
                end
                if (!w_own_active) begin
                    // Owner withdrew: leave without ack, priority untouched.
                    w_next_state = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    if (w_own_i) iwait[w_core] = 1'b0;
                    else         dwait[w_core] = 1'b0;
                    w_next_state = IDLE;
                    w_next_rp    = (r_owner == SW'(NS - 1)) ? '0 : r_owner + 1'b1;
                end else if (ramstate == RAM_ERROR) begin
                    // Drop the grant; the still-asserted request is re-arbitrated.
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - randomized and directed self-checking bench for memory_arbiter

module tb_memory_arbiter;

    localparam int CPUS = 2;
    localparam int NS   = 2 * CPUS;

    logic              CLK;
    logic              nRST;
    logic [CPUS-1:0]   iREN, dREN, dWEN;
    logic [63:0]       iaddr, daddr, dstore;
    logic [CPUS-1:0]   iwait, dwait;
    logic [63:0]       iload, dload;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    logic [1:0]        ramstate;

    memory_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: whether a grant is held, by which source, and the
    // source that has first claim at the next arbitration.
    bit m_granted;
    int m_owner;
    int m_rp;
    int obs[$];

    logic [CPUS-1:0] s_iwait, s_dwait;
    logic            s_ren, s_wen;
    logic [31:0]     s_addr, s_store;
    logic [63:0]     s_iload;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit src_active(input int s);
        return (s % 2 == 1) ? iREN[s/2] : (dREN[s/2] | dWEN[s/2]);
    endfunction

    task automatic model_reset();
        m_granted = 0;
        m_owner   = 0;
        m_rp      = 0;
    endtask

    // Called at posedge+1; checks mid-cycle, returns at next posedge+1.
    task automatic step();
        logic [CPUS-1:0] e_iwait, e_dwait;
        logic            e_ren, e_wen;
        logic [31:0]     e_addr, e_store;
        bit              n_granted;
        int              n_owner, n_rp, c, best, bestkey, key;
        #4;
        s_iwait = iwait; s_dwait = dwait; s_ren = ramREN; s_wen = ramWEN;
        s_addr = ramaddr; s_store = ramstore; s_iload = iload;
        e_iwait = '1; e_dwait = '1; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        n_granted = m_granted; n_owner = m_owner; n_rp = m_rp;
        if (m_granted) begin
            c = m_owner / 2;
            if (m_owner % 2 == 1) begin
                e_addr = iaddr[32*c +: 32];
                e_ren  = iREN[c];
            end else begin
                e_addr  = daddr[32*c +: 32];
                e_store = dstore[32*c +: 32];
                e_wen   = dWEN[c];
                e_ren   = dREN[c] && !dWEN[c];
            end
            if (!src_active(m_owner)) begin
                n_granted = 0;
            end else if (ramstate == 2'd2) begin
                if (m_owner % 2 == 1) e_iwait[c] = 1'b0;
                else                  e_dwait[c] = 1'b0;
                n_granted = 0;
                n_rp = (m_owner + 1) % NS;
            end else if (ramstate == 2'd3) begin
                n_granted = 0;
            end
        end else begin
            best = -1;
            bestkey = 3 * NS;
            for (int s = 0; s < NS; s++) begin
                if (src_active(s)) begin
                    key = (s - m_rp + NS) % NS;
`ifdef ARB_DATA_PRIORITY_EN
                    if (s % 2 == 1) key += NS;
`endif
                    if (key < bestkey) begin
                        bestkey = key;
                        best = s;
                    end
                end
            end
            if (best >= 0) begin
                n_granted = 1;
                n_owner = best;
            end
        end
        check("iwait", 64'(s_iwait), 64'(e_iwait));
        check("dwait", 64'(s_dwait), 64'(e_dwait));
        check("ramREN", 64'(s_ren), 64'(e_ren));
        check("ramWEN", 64'(s_wen), 64'(e_wen));
        check("ramaddr", 64'(s_addr), 64'(e_addr));
        check("ramstore", 64'(s_store), 64'(e_store));
        check("iload", s_iload, {ramload, ramload});
        check("dload", dload, {ramload, ramload});
        for (int s = 0; s < NS; s++) begin
            if (((s % 2 == 1) ? s_iwait[s/2] : s_dwait[s/2]) == 1'b0) obs.push_back(s);
        end
        @(posedge CLK); #1;
        m_granted = n_granted; m_owner = n_owner; m_rp = n_rp;
    endtask

    // Called at posedge+1; asserts reset mid-cycle and releases it one cycle later.
    task automatic do_reset();
        #2 nRST = 1'b0;
        #1;
        check("rst_ren", 64'(ramREN), 64'd0);
        check("rst_wen", 64'(ramWEN), 64'd0);
        check("rst_iwait", 64'(iwait), 64'h3);
        check("rst_dwait", 64'(dwait), 64'h3);
        check("rst_addr", 64'(ramaddr), 64'd0);
        check("rst_store", 64'(ramstore), 64'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic clear_reqs();
        iREN = '0; dREN = '0; dWEN = '0; ramstate = 2'd0;
        step();
        step();
    endtask

    task automatic rand_inputs();
        int r;
        for (int c = 0; c < CPUS; c++) begin
            if ($urandom_range(0, 5) == 0) iREN[c] = ~iREN[c];
            if ($urandom_range(0, 5) == 0) dREN[c] = ~dREN[c];
            if ($urandom_range(0, 9) == 0) dWEN[c] = ~dWEN[c];
        end
        iaddr  = {$urandom, $urandom};
        daddr  = {$urandom, $urandom};
        dstore = {$urandom, $urandom};
        ramload = $urandom;
        r = $urandom_range(0, 9);
        ramstate = (r < 5) ? 2'd1 : (r < 8) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
    endtask

    int exp_order[5];

    initial begin
        nRST = 1'b0;
        iREN = 2'b11; dREN = 2'b11; dWEN = '0;
        iaddr = 64'h0000_0200_0000_0100; daddr = 64'h0000_0400_0000_0300;
        dstore = '0; ramload = '0; ramstate = 2'd0;
        model_reset();

        // Reset held with requests active, then first grant after release.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("reset_iwait", 64'(iwait), 64'h3);
        check("reset_dwait", 64'(dwait), 64'h3);
        check("reset_ren", 64'(ramREN), 64'd0);
        check("reset_wen", 64'(ramWEN), 64'd0);
        check("reset_addr", 64'(ramaddr), 64'd0);
        nRST = 1'b1;
        step();
        step();
        check("first_grant_ren", 64'(s_ren), 64'd1);
        check("first_grant_addr", 64'(s_addr), 64'h300);
        clear_reqs();

        // Single instruction fetch with three BUSY cycles.
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = 2'd1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("fetch_addr", 64'(s_addr), 64'h40);
            check("fetch_busy_wait", 64'(s_iwait[0]), 64'd1);
        end
        ramstate = 2'd2; ramload = 32'hDEAD_BEEF;
        step();
        check("fetch_ack", 64'(s_iwait[0]), 64'd0);
        check("fetch_iload", 64'(s_iload[31:0]), 64'hDEAD_BEEF);
        iREN = '0; ramstate = 2'd1;
        step();
        check("fetch_ack_one_cycle", 64'(s_iwait[0]), 64'd1);

        // Write from core 1.
        dWEN = 2'b10; daddr[63:32] = 32'h80; dstore[63:32] = 32'h1234; ramstate = 2'd2;
        step();
        step();
        check("wr_wen", 64'(s_wen), 64'd1);
        check("wr_ren", 64'(s_ren), 64'd0);
        check("wr_addr", 64'(s_addr), 64'h80);
        check("wr_store", 64'(s_store), 64'h1234);
        check("wr_ack", 64'(s_dwait[1]), 64'd0);
        clear_reqs();

        // All four ports requesting, RAM ACCESS every cycle, from rp = 0.
        do_reset();
        iREN = 2'b11; dREN = 2'b11; ramstate = 2'd2;
        obs.delete();
        for (int k = 0; k < 10; k++) step();
`ifdef ARB_DATA_PRIORITY_EN
        exp_order = '{0, 2, 0, 2, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        check("order_count", 64'(obs.size()), 64'd5);
        for (int k = 0; k < 5 && k < obs.size(); k++) check("order", 64'(obs[k]), 64'(exp_order[k]));
        clear_reqs();

        // Owner (d1) drops mid-BUSY; rp stays 0 so d0 beats i1 afterwards.
        do_reset();
        dREN = 2'b10; ramstate = 2'd1;
        step();
        step();
        check("drop_granted", 64'(s_ren), 64'd1);
        dREN = 2'b01; iREN = 2'b10;
        step();
        check("drop_no_ack", 64'(s_dwait), 64'h3);
        ramstate = 2'd2;
        step();
        step();
        check("drop_next_ack_d0", 64'(s_dwait[0]), 64'd0);
        check("drop_i1_waits", 64'(s_iwait[1]), 64'd1);
        clear_reqs();

        // ERROR aborts without ack and the request is granted again 2 cycles later.
        do_reset();
        iREN = 2'b10; iaddr[63:32] = 32'h5500; ramstate = 2'd3;
        step();
        step();
        check("err_no_ack", 64'(s_iwait[1]), 64'd1);
        check("err_ren", 64'(s_ren), 64'd1);
        ramstate = 2'd1;
        step();
        check("err_idle_ren", 64'(s_ren), 64'd0);
        step();
        check("err_regrant_ren", 64'(s_ren), 64'd1);
        check("err_regrant_addr", 64'(s_addr), 64'h5500);
        clear_reqs();

        // Read and write together: write only.
        dREN = 2'b01; dWEN = 2'b01; ramstate = 2'd2;
        step();
        step();
        check("rw_wen", 64'(s_wen), 64'd1);
        check("rw_ren", 64'(s_ren), 64'd0);
        check("rw_ack", 64'(s_dwait[0]), 64'd0);

        // Reset during a held grant: enables drop immediately.
        dWEN = '0; dREN = 2'b01; ramstate = 2'd1;
        step();
        step();
        check("midrst_granted", 64'(s_ren), 64'd1);
        do_reset();
        clear_reqs();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
